// File: rtl/simd_seq_ctrl_if.sv
// Pico parallel bus between the Pico host and the SIMD sequencer.
//
// Signals:
//   cs       chip select, active-high, asynchronous to the FPGA clock
//   wr       write strobe, rising edge starts an address or data cycle
//   rd       read strobe, rising edge fetches the next byte
//   cd       cycle type: 1 = address cycle, 0 = data cycle
//   dir      bus direction: 1 = FPGA drives, 0 = Pico drives
//   bus_din  write data from the Pico
//   bus_dout read data towards the Pico
//   bus_oe   tristate enable for the FPGA pad drivers
//
// Modports: master is the Pico side, slave is the sequencer side.
interface simd_seq_ctrl_if;
    logic       cs;
    logic       wr;
    logic       rd;
    logic       cd;
    logic       dir;
    logic [7:0] bus_din;
    logic [7:0] bus_dout;
    logic       bus_oe;

    modport master (
        output cs, wr, rd, cd, dir, bus_din,
        input  bus_dout, bus_oe
    );

    modport slave (
        input  cs, wr, rd, cd, dir, bus_din,
        output bus_dout, bus_oe
    );
endinterface

// File: rtl/simd_seq_ctrl.sv
// Sequencer and bus arbiter for the SIMD byte-vector engine.
//
// Decodes Pico bus address/data cycles and read strobes into accesses to a
// shared single-port operand RAM, runs an element-wise ALU operation over
// vectors A and B into the result area on an execute pulse, and streams bytes
// back to the Pico through an auto-incrementing read pointer.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   bus        Pico bus (slave modport of simd_seq_ctrl_if)
//   execute    asynchronous start strobe, rising edge starts a vector op
//   mem_addr   RAM address
//   mem_wdata  RAM write data
//   mem_we     RAM write enable
//   mem_rdata  RAM read data, valid one clock after mem_addr
//   busy       vector operation in progress
//   done       one-clock pulse when a vector operation completes
module simd_seq_ctrl #(
    parameter int         VEC_LEN = 32,
    parameter logic [7:0] A_BASE  = 8'h00,
    parameter logic [7:0] B_BASE  = 8'h20,
    parameter logic [7:0] R_BASE  = 8'h80,
    parameter logic [7:0] OP_ADDR = 8'h40
) (
    input  logic                  clk,
    input  logic                  rst,
    simd_seq_ctrl_if.slave        bus,
    input  logic                  execute,
    output logic [7:0]            mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    input  logic [7:0]            mem_rdata,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FETCH_A = 3'd1;
    localparam logic [2:0] FETCH_B = 3'd2;
    localparam logic [2:0] CAPT_B  = 3'd3;
    localparam logic [2:0] WRITE   = 3'd4;
    localparam logic [2:0] FINISH  = 3'd5;

    localparam logic [4:0] LAST_IDX = 5'(VEC_LEN - 1);

    // Bit 2 of each strobe chain is the previous synchronised value, used
    // only for rising-edge detection.
    logic [2:0] wr_sync;
    logic [2:0] rd_sync;
    logic [2:0] ex_sync;
    logic [1:0] cs_sync;

    logic [2:0] state;
    logic [4:0] idx;
    logic [7:0] a_reg;
    logic [7:0] addr_reg;
    logic [7:0] rd_ptr;
    logic [1:0] opcode;
    logic       rd_pending;
    logic [1:0] rd_pipe;

    logic wr_evt;
    logic rd_evt;
    logic ex_evt;

    function automatic logic [7:0] alu_op(input logic [1:0] op,
                                          input logic [7:0] x,
                                          input logic [7:0] y);
        logic [8:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        case (op)
            2'd0:    alu_op = sum[7:0];
            2'd1:    alu_op = x - y;
            2'd2:    alu_op = x & y;
            default: alu_op = sum[8] ? 8'hFF : sum[7:0];
        endcase
    endfunction

    assign bus.bus_oe = bus.cs & bus.dir;

    assign wr_evt = wr_sync[1] & ~wr_sync[2] & cs_sync[1];
    assign rd_evt = rd_sync[1] & ~rd_sync[2] & cs_sync[1];
    assign ex_evt = ex_sync[1] & ~ex_sync[2] & cs_sync[1];

    // cd and bus_din are sampled raw: the Pico holds them stable for the
    // whole strobe, long after the synchronised edge has been acted on.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sync <= '0;
            rd_sync <= '0;
            ex_sync <= '0;
            cs_sync <= '0;
        end else begin
            wr_sync <= {wr_sync[1:0], bus.wr};
            rd_sync <= {rd_sync[1:0], bus.rd};
            ex_sync <= {ex_sync[1:0], execute};
            cs_sync <= {cs_sync[0], bus.cs};
        end
    end

    // Single owner of the RAM port. rd_pipe tracks an issued read through
    // the RAM latency: address goes out, data appears a clock later, and it
    // lands in bus_dout the clock after that. Reads already in flight when
    // an operation starts still complete, because the RAM returns their
    // data before the FSM's first fetch does.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            a_reg        <= '0;
            addr_reg     <= '0;
            rd_ptr       <= '0;
            opcode       <= '0;
            rd_pending   <= 1'b0;
            rd_pipe      <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus.bus_dout <= '0;
        end else begin
            mem_we     <= 1'b0;
            done       <= 1'b0;
            rd_pipe[0] <= 1'b0;
            rd_pipe[1] <= rd_pipe[0];
            if (rd_pipe[1]) begin
                bus.bus_dout <= mem_rdata;
            end

            case (state)
                IDLE: begin
                    if (ex_evt) begin
                        state      <= FETCH_A;
                        busy       <= 1'b1;
                        idx        <= '0;
                        mem_addr   <= A_BASE;
                        rd_pending <= 1'b0;
                    end else if (wr_evt) begin
                        if (bus.cd) begin
                            // Address cycle doubles as a prefetch so the
                            // first read strobe returns the following byte.
                            addr_reg   <= bus.bus_din;
                            mem_addr   <= bus.bus_din;
                            rd_ptr     <= bus.bus_din + 8'd1;
                            rd_pipe[0] <= 1'b1;
                        end else begin
                            if (addr_reg == OP_ADDR) begin
                                opcode <= bus.bus_din[1:0];
                            end else begin
                                mem_we    <= 1'b1;
                                mem_addr  <= addr_reg;
                                mem_wdata <= bus.bus_din;
                            end
                            addr_reg <= addr_reg + 8'd1;
                        end
                        // A coincident read waits one clock for the port.
                        if (rd_evt) begin
                            rd_pending <= 1'b1;
                        end
                    end else if (rd_evt || rd_pending) begin
                        mem_addr   <= rd_ptr;
                        rd_ptr     <= rd_ptr + 8'd1;
                        rd_pipe[0] <= 1'b1;
                        rd_pending <= 1'b0;
                    end
                end
                FETCH_A: begin
                    mem_addr <= B_BASE + {3'b000, idx};
                    state    <= FETCH_B;
                end
                FETCH_B: begin
                    a_reg <= mem_rdata;
                    state <= CAPT_B;
                end
                CAPT_B: begin
                    // B arrives this clock; combine it directly instead of
                    // spending a clock holding it in a register.
                    mem_wdata <= alu_op(opcode, a_reg, mem_rdata);
                    mem_we    <= 1'b1;
                    mem_addr  <= R_BASE + {3'b000, idx};
                    state     <= WRITE;
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        state <= FINISH;
                    end else begin
                        idx      <= idx + 5'd1;
                        mem_addr <= A_BASE + {3'b000, idx} + 8'd1;
                        state    <= FETCH_A;
                    end
                end
                FINISH: begin
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    mem_addr   <= R_BASE;
                    rd_ptr     <= R_BASE + 8'd1;
                    rd_pipe[0] <= 1'b1;
                    rd_pending <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simd_seq_ctrl.sv
// Directed testbench for simd_seq_ctrl: a behavioural single-port RAM with
// one clock of read latency, a Pico bus driver and hand-computed expectations.
module tb_simd_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       execute;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;

    simd_seq_ctrl_if pico ();

    simd_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (pico),
        .execute   (execute),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Operand RAM: synchronous write, registered read.
    logic [7:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Bus activity monitor, sampled on the falling edge.
    int         done_cnt = 0;
    int         we_cnt = 0;
    int         bad_we = 0;
    logic [7:0] last_we_addr = 8'h00;
    logic [7:0] last_we_data = 8'h00;
    logic [7:0] addr_after_we = 8'h00;
    logic       prev_we = 1'b0;
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (mem_we) begin
            we_cnt       <= we_cnt + 1;
            last_we_addr <= mem_addr;
            last_we_data <= mem_wdata;
            if (busy && (mem_addr < 8'h80 || mem_addr > 8'h9F)) bad_we <= bad_we + 1;
        end
        if (prev_we) addr_after_we <= mem_addr;
        prev_we <= mem_we;
    end

    int checkCount = 0;
    int failCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // One strobe on the Pico bus: 3 clocks high, 3 clocks low.
    task automatic applyStimulus(input logic is_rd, input logic cd_val,
                                 input logic [7:0] data);
        @(negedge clk);
        pico.cd      = cd_val;
        pico.bus_din = data;
        if (is_rd) pico.rd = 1'b1;
        else       pico.wr = 1'b1;
        repeat (3) @(negedge clk);
        pico.rd = 1'b0;
        pico.wr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic writeAddr(input logic [7:0] a);
        applyStimulus(1'b0, 1'b1, a);
    endtask

    task automatic writeData(input logic [7:0] d);
        applyStimulus(1'b0, 1'b0, d);
    endtask

    task automatic readByte();
        applyStimulus(1'b1, 1'b0, 8'h00);
    endtask

    task automatic pulseExecute();
        @(negedge clk);
        execute = 1'b1;
        repeat (3) @(negedge clk);
        execute = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Waits (bounded) for busy, counts the clocks it stays high and samples
    // done on the first clock it is low again. len = 0 means busy never rose.
    task automatic measureBusy(output int len, output logic done_at_fall);
        int guard;
        guard = 0;
        len = 0;
        done_at_fall = 1'b0;
        while (!busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            while (busy && len < 300) begin
                len++;
                @(negedge clk);
            end
            done_at_fall = done;
        end
    endtask

    task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [7:0] expected);
        int   len;
        logic dfall;
        writeAddr(8'h00);
        writeData(a);
        writeAddr(8'h20);
        writeData(b);
        writeAddr(8'h40);
        writeData(op);
        fork
            pulseExecute();
            measureBusy(len, dfall);
        join
        checkOutput({tag, "_busy_len"}, len, 129);
        repeat (6) @(negedge clk);
        checkOutput({tag, "_r0"}, pico.bus_dout, expected);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         len;
        int         snap_we;
        int         snap_done;
        int         snap_bad;
        logic       dfall;
        logic [7:0] exp_byte;

        rst = 1'b1;
        execute = 1'b0;
        pico.cs = 1'b0;
        pico.wr = 1'b0;
        pico.rd = 1'b0;
        pico.cd = 1'b0;
        pico.dir = 1'b0;
        pico.bus_din = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_bus_dout", pico.bus_dout, 8'h00);
        checkOutput("rst_mem_addr", mem_addr, 8'h00);
        checkOutput("rst_mem_wdata", mem_wdata, 8'h00);
        checkOutput("rst_mem_we", mem_we, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        rst = 1'b0;
        pico.cs = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] address/data write");
        snap_we = we_cnt;
        writeAddr(8'h05);
        checkOutput("addr_cycle_no_we", we_cnt - snap_we, 0);
        writeData(8'hA5);
        checkOutput("data_we_count", we_cnt - snap_we, 1);
        checkOutput("data_we_addr", last_we_addr, 8'h05);
        checkOutput("data_we_data", last_we_data, 8'hA5);
        writeData(8'h5A);
        checkOutput("data2_we_addr", last_we_addr, 8'h06);
        checkOutput("data2_we_data", last_we_data, 8'h5A);

        pico.dir = 1'b1;
        #1;
        checkOutput("oe_cs_dir", pico.bus_oe, 1'b1);
        pico.dir = 1'b0;
        #1;
        checkOutput("oe_dir_low", pico.bus_oe, 1'b0);

        $display("[TB] load vectors");
        snap_we = we_cnt;
        writeAddr(8'hFE);
        writeData(8'h11);
        writeData(8'h22);
        for (int i = 0; i < 32; i++) writeData(8'(i));
        writeAddr(8'h20);
        for (int i = 0; i < 32; i++) writeData(8'h0F);
        writeAddr(8'hA0);
        for (int k = 0; k < 9; k++) writeData(8'hC0 + 8'(k));
        checkOutput("load_we_count", we_cnt - snap_we, 75);
        snap_we = we_cnt;
        writeAddr(8'h40);
        writeData(8'h00);
        checkOutput("opcode_no_ram_write", we_cnt - snap_we, 0);

        $display("[TB] vector ADD with bus activity during busy");
        snap_we = we_cnt;
        snap_done = done_cnt;
        snap_bad = bad_we;
        fork
            pulseExecute();
            measureBusy(len, dfall);
            begin
                repeat (20) @(negedge clk);
                writeAddr(8'h05);
                writeData(8'h77);
                readByte();
                pulseExecute();
            end
        join
        checkOutput("add_busy_len", len, 129);
        checkOutput("add_done_at_fall", dfall, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("add_done_count", done_cnt - snap_done, 1);
        checkOutput("add_we_count", we_cnt - snap_we, 32);
        checkOutput("busy_wr_dropped", bad_we - snap_bad, 0);
        checkOutput("exec_during_busy_ignored", busy, 1'b0);
        checkOutput("prefetch_r0", pico.bus_dout, 8'h0F);

        $display("[TB] readback");
        for (int k = 1; k <= 40; k++) begin
            readByte();
            if (k < 32) exp_byte = 8'h0F + 8'(k);
            else        exp_byte = 8'hC0 + 8'(k - 32);
            checkOutput($sformatf("readback_%0d", k), pico.bus_dout, exp_byte);
        end

        $display("[TB] read pointer wrap");
        writeAddr(8'hFE);
        checkOutput("wrap_fe", pico.bus_dout, 8'h11);
        readByte();
        checkOutput("wrap_ff", pico.bus_dout, 8'h22);
        readByte();
        checkOutput("wrap_00", pico.bus_dout, 8'h00);
        readByte();
        checkOutput("wrap_01", pico.bus_dout, 8'h01);

        $display("[TB] chip select low");
        @(negedge clk);
        pico.cs = 1'b0;
        pico.dir = 1'b1;
        #1;
        checkOutput("oe_cs_low", pico.bus_oe, 1'b0);
        repeat (4) @(negedge clk);
        snap_we = we_cnt;
        writeAddr(8'h03);
        writeData(8'h99);
        readByte();
        checkOutput("cs_low_no_we", we_cnt - snap_we, 0);
        checkOutput("cs_low_no_read", pico.bus_dout, 8'h01);
        pico.cs = 1'b1;
        pico.dir = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] simultaneous write and read");
        writeAddr(8'h10);
        checkOutput("sim_prefetch", pico.bus_dout, 8'h10);
        @(negedge clk);
        pico.cd = 1'b0;
        pico.bus_din = 8'hEE;
        pico.wr = 1'b1;
        pico.rd = 1'b1;
        repeat (3) @(negedge clk);
        pico.wr = 1'b0;
        pico.rd = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("sim_we_addr", last_we_addr, 8'h10);
        checkOutput("sim_we_data", last_we_data, 8'hEE);
        checkOutput("sim_read_next_clk", addr_after_we, 8'h11);
        checkOutput("sim_read_data", pico.bus_dout, 8'h11);
        writeAddr(8'h0F);
        readByte();
        checkOutput("sim_written_byte", pico.bus_dout, 8'hEE);

        $display("[TB] ALU opcodes");
        runOp("sat_add", 8'hF0, 8'h20, 8'h03, 8'hFF);
        runOp("add_wrap", 8'hF0, 8'h20, 8'h00, 8'h10);
        runOp("and", 8'hF0, 8'h3C, 8'h02, 8'h30);
        runOp("sub_wrap", 8'h00, 8'h01, 8'h01, 8'hFF);

        $display("[TB] reset mid-operation");
        writeAddr(8'h40);
        writeData(8'h00);
        snap_done = done_cnt;
        fork
            pulseExecute();
            begin
                measureBusyStart();
                repeat (40) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                checkOutput("midrst_busy", busy, 1'b0);
                checkOutput("midrst_mem_we", mem_we, 1'b0);
                rst = 1'b0;
            end
        join
        repeat (150) @(negedge clk);
        checkOutput("midrst_no_done", done_cnt - snap_done, 0);
        checkOutput("midrst_idle", busy, 1'b0);
        snap_done = done_cnt;
        fork
            pulseExecute();
            measureBusy(len, dfall);
        join
        checkOutput("after_rst_busy_len", len, 129);
        repeat (6) @(negedge clk);
        checkOutput("after_rst_done", done_cnt - snap_done, 1);
        checkOutput("after_rst_r0", pico.bus_dout, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    // Bounded wait for busy to rise; an expired bound is a failed comparison.
    task automatic measureBusyStart();
        int guard;
        guard = 0;
        while (!busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("midrst_busy_rose", busy, 1'b1);
    endtask

endmodule
